// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and defaults for the fetch redirect controller.
// Holds the FSM state encoding and the default reset PC.
package fetch_redirect_ctrl_pkg;

    typedef enum logic [0:0] {
        FRC_RUN        = 1'b0,
        FRC_REDIR_WAIT = 1'b1
    } frc_state_t;

    localparam logic [31:0] FRC_DEF_RESET_PC = 32'h0000_0000;

    // Instruction fetch is word granular; the low two target bits are dropped.
    function automatic logic target_misaligned(input logic [1:0] low_bits);
        return |low_bits;
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl.sv
// Purpose: owns the fetch PC, applies EX branch/jump redirects, squashes wrong-path work, gates fetch.
// Latency: redirect target fetched 1 cycle after the redirect cycle, plus n cycles of mem_busy.
// Backpressure: stall/mem_busy hold the PC; a redirect blocked by mem_busy parks in REDIR_WAIT.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FRC_DEF_RESET_PC),
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch_sel,
    input  logic             jump,
    input  logic [XLEN-1:0]  target_addr,
    input  logic             stall,
    input  logic             mem_busy,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             fetch_req,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             misaligned,
    output logic [CNT_W-1:0] redirect_cnt
);

    frc_state_t         r_state;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_pend;
    logic [CNT_W-1:0]   r_cnt;

    frc_state_t         w_state_nxt;
    logic [XLEN-1:0]    w_pc_nxt;
    logic [XLEN-1:0]    w_pend_nxt;
    logic [XLEN-1:0]    w_tgt;
    logic [XLEN-1:0]    w_pc_plus4;
    logic               w_redirect;
    logic               w_cnt_en;
    logic               w_fetch;
    logic               w_flush_if_id;
    logic               w_flush_id_ex;

    assign w_tgt      = {target_addr[XLEN-1:2], 2'b00};
    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_redirect = (branch_sel | jump) && (r_state == FRC_RUN);

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pend_nxt    = r_pend;
        w_cnt_en      = 1'b0;
        w_fetch       = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        case (r_state)
            FRC_RUN: begin
                if (w_redirect) begin
                    // EX is authoritative: a redirect overrides stall.
                    w_flush_if_id = 1'b1;
                    w_flush_id_ex = 1'b1;
                    w_cnt_en      = 1'b1;
                    if (mem_busy) begin
                        w_pend_nxt  = w_tgt;
                        w_state_nxt = FRC_REDIR_WAIT;
                    end else begin
                        w_pc_nxt = w_tgt;
                    end
                end else begin
                    w_fetch = ~stall & ~mem_busy;
                    if (w_fetch) begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end
            end
            FRC_REDIR_WAIT: begin
                // ID/EX was squashed on entry; keep bubbling IF/ID until the memory frees up.
                w_flush_if_id = 1'b1;
                if (!mem_busy) begin
                    w_pc_nxt    = r_pend;
                    w_state_nxt = FRC_RUN;
                end
            end
            default: begin
                w_state_nxt = FRC_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FRC_RUN;
            r_pc    <= RESET_PC;
            r_pend  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_pend  <= w_pend_nxt;
            if (w_cnt_en) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_out       = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign redirect_cnt = r_cnt;
    assign fetch_req    = w_fetch       & ~rst;
    assign flush_if_id  = w_flush_if_id & ~rst;
    assign flush_id_ex  = w_flush_id_ex & ~rst;
    assign misaligned   = w_redirect & target_misaligned(target_addr[1:0]) & ~rst;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: a driver pushes hand-computed expectations per cycle,
// a monitor pops and compares them on the falling edge.
module tb_fetch_redirect_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic        fr;
        logic        fif;
        logic        fie;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch_sel = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] target_addr = '0;
    logic        stall = 1'b0;
    logic        mem_busy = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_req;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        misaligned;
    logic [31:0] redirect_cnt;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    fetch_redirect_ctrl #(
        .XLEN     (32),
        .RESET_PC (32'h0),
        .CNT_W    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .branch_sel   (branch_sel),
        .jump         (jump),
        .target_addr  (target_addr),
        .stall        (stall),
        .mem_busy     (mem_busy),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .fetch_req    (fetch_req),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .misaligned   (misaligned),
        .redirect_cnt (redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int vec, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", vec, name, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle, so one expectation is consumed per falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_out",       n_vec, pc_out,              e.pc);
            chk("pc_plus4",     n_vec, pc_plus4,            e.pc + 32'd4);
            chk("fetch_req",    n_vec, {31'd0, fetch_req},  {31'd0, e.fr});
            chk("flush_if_id",  n_vec, {31'd0, flush_if_id},{31'd0, e.fif});
            chk("flush_id_ex",  n_vec, {31'd0, flush_id_ex},{31'd0, e.fie});
            chk("misaligned",   n_vec, {31'd0, misaligned}, {31'd0, e.mis});
            chk("redirect_cnt", n_vec, redirect_cnt,        e.cnt);
            n_vec++;
        end
    end

    // Driver: apply inputs just after the rising edge and queue the outputs expected this cycle.
    task automatic step(input logic r, input logic bs, input logic jp, input logic [31:0] tg,
                        input logic st, input logic mb,
                        input logic [31:0] epc, input logic efr, input logic efif,
                        input logic efie, input logic emis, input logic [31:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        branch_sel  = bs;
        jump        = jp;
        target_addr = tg;
        stall       = st;
        mem_busy    = mb;
        e.pc  = epc;
        e.fr  = efr;
        e.fif = efif;
        e.fie = efie;
        e.mis = emis;
        e.cnt = ecnt;
        exp_q.push_back(e);
    endtask

    initial begin
        // rst bs jp target        st mb   pc            fr fif fie mis cnt
        // reset holds outputs quiet even with a branch on the inputs
        step(1, 1, 0, 32'h100,      0, 0,  32'h0,        0, 0, 0, 0, 0);
        // sequential fetch from RESET_PC
        step(0, 0, 0, 32'h0,        0, 0,  32'h0,        1, 0, 0, 0, 0);
        step(0, 0, 0, 32'h0,        0, 0,  32'h4,        1, 0, 0, 0, 0);
        step(0, 0, 0, 32'h0,        0, 0,  32'h8,        1, 0, 0, 0, 0);
        step(0, 0, 0, 32'h0,        0, 0,  32'hC,        1, 0, 0, 0, 0);
        step(0, 0, 0, 32'h0,        0, 0,  32'h10,       1, 0, 0, 0, 0);
        step(0, 0, 0, 32'h0,        0, 0,  32'h14,       1, 0, 0, 0, 0);
        step(0, 0, 0, 32'h0,        0, 0,  32'h18,       1, 0, 0, 0, 0);
        step(0, 0, 0, 32'h0,        0, 0,  32'h1C,       1, 0, 0, 0, 0);
        // taken branch at 0x20 -> 0x100
        step(0, 1, 0, 32'h100,      0, 0,  32'h20,       0, 1, 1, 0, 0);
        step(0, 0, 0, 32'h0,        0, 0,  32'h100,      1, 0, 0, 0, 1);
        // jump to 0x200 while MEM owns memory for 3 cycles; jump held high is ignored in wait
        step(0, 0, 1, 32'h200,      0, 1,  32'h104,      0, 1, 1, 0, 1);
        step(0, 0, 1, 32'h203,      0, 1,  32'h104,      0, 1, 0, 0, 2);
        step(0, 0, 1, 32'h203,      0, 1,  32'h104,      0, 1, 0, 0, 2);
        step(0, 0, 0, 32'h0,        0, 0,  32'h104,      0, 1, 0, 0, 2);
        step(0, 0, 0, 32'h0,        0, 0,  32'h200,      1, 0, 0, 0, 2);
        // mem_busy alone holds the PC without flushing
        step(0, 0, 0, 32'h0,        0, 1,  32'h204,      0, 0, 0, 0, 2);
        step(0, 1, 0, 32'h40,       0, 0,  32'h204,      0, 1, 1, 0, 2);
        // stall holds at 0x40, then a branch overrides stall
        step(0, 0, 0, 32'h0,        1, 0,  32'h40,       0, 0, 0, 0, 3);
        step(0, 0, 0, 32'h0,        1, 0,  32'h40,       0, 0, 0, 0, 3);
        step(0, 1, 0, 32'h80,       1, 0,  32'h40,       0, 1, 1, 0, 3);
        step(0, 0, 0, 32'h0,        0, 0,  32'h80,       1, 0, 0, 0, 4);
        // misaligned target 0x103 is taken as 0x100
        step(0, 1, 0, 32'h103,      0, 0,  32'h84,       0, 1, 1, 1, 4);
        step(0, 0, 0, 32'h0,        0, 0,  32'h100,      1, 0, 0, 0, 5);
        // jump to top of address space, then wrap to 0
        step(0, 0, 1, 32'hFFFF_FFFE,0, 0,  32'h104,      0, 1, 1, 1, 5);
        step(0, 0, 0, 32'h0,        0, 0,  32'hFFFF_FFFC,1, 0, 0, 0, 6);
        step(0, 0, 0, 32'h0,        0, 0,  32'h0,        1, 0, 0, 0, 6);
        // redirect to 0x300 parked in wait, then reset discards it
        step(0, 0, 1, 32'h300,      0, 1,  32'h4,        0, 1, 1, 0, 6);
        step(0, 0, 0, 32'h0,        0, 1,  32'h4,        0, 1, 0, 0, 7);
        step(1, 0, 0, 32'h0,        0, 1,  32'h0,        0, 0, 0, 0, 0);
        step(0, 0, 0, 32'h0,        0, 0,  32'h0,        1, 0, 0, 0, 0);
        step(0, 0, 0, 32'h0,        0, 0,  32'h4,        1, 0, 0, 0, 0);
        step(0, 0, 0, 32'h0,        0, 0,  32'h8,        1, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
